// File: rtl/debounce_pkg.sv
// Shared types and defaults for the debouncer and its users.
package debounce_pkg;

   // Debouncer states. In this encoding bit 1 is the accepted level and
   // bit 0 is set while a candidate transition is being qualified.
   typedef enum logic [1:0] {
      ST_LOW    = 2'd0,
      WAIT_HIGH = 2'd1,
      ST_HIGH   = 2'd2,
      WAIT_LOW  = 2'd3
   } state_t;

   localparam int unsigned DEBOUNCE_CYCLES_DEF = 32'd4;

endpackage

// File: rtl/debouncer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level. The two flops
// are back to back, with no logic between them, so the first flop has a
// full cycle to settle out of metastability.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d_i,
   output logic q_o
);

   logic r_meta;
   logic r_sync;

   // Shift the raw input through the two synchronizing flops.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
      end else begin
         r_meta <= d_i;
         r_sync <= r_meta;
      end
   end

   assign q_o = r_sync;

endmodule

// File: rtl/debouncer.sv
// Debouncer: synchronizes a raw level, then accepts a new level only
// after DEBOUNCE_CYCLES consecutive equal samples. An aborted
// qualification produces a one-cycle glitch pulse.
module debouncer
   import debounce_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter logic        RESET_VAL       = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic a_i,
   output logic level_o,
   output logic busy_o,
   output logic glitch_o
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 32'd1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
   localparam state_t RESET_STATE = (RESET_VAL == 1'b1) ? ST_HIGH : ST_LOW;

   // A single-cycle qualification window would make the debouncer a plain
   // re-register of the synchronizer; refuse to build that.
   if (DEBOUNCE_CYCLES < 32'd2) begin : g_cycles_too_small
      $error("debouncer: DEBOUNCE_CYCLES must be at least 2");
   end
   if (DEBOUNCE_CYCLES > 32'd65535) begin : g_cycles_too_large
      $error("debouncer: DEBOUNCE_CYCLES must be at most 65535");
   end

   logic             w_s;
   state_t           r_state;
   state_t           w_next_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_next_cnt;
   logic             r_glitch;
   logic             w_next_glitch;

   sync_2ff #(
      .RESET_VAL (RESET_VAL)
   ) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d_i     (a_i),
      .q_o     (w_s)
   );

   // Next-state, counter and glitch logic. A WAIT state always starts at
   // cnt=1 so an abort never leaves a partial count behind.
   always_comb begin
      w_next_state  = r_state;
      w_next_cnt    = r_cnt;
      w_next_glitch = 1'b0;
      case (r_state)
         ST_LOW: begin
            if (w_s) begin
               w_next_state = WAIT_HIGH;
               w_next_cnt   = CNT_ONE;
            end else begin
               w_next_cnt   = CNT_ZERO;
            end
         end
         WAIT_HIGH: begin
            if (!w_s) begin
               w_next_state  = ST_LOW;
               w_next_cnt    = CNT_ZERO;
               w_next_glitch = 1'b1;
            end else if (r_cnt == CNT_LAST) begin
               w_next_state = ST_HIGH;
               w_next_cnt   = CNT_ZERO;
            end else begin
               w_next_cnt   = r_cnt + CNT_ONE;
            end
         end
         ST_HIGH: begin
            if (!w_s) begin
               w_next_state = WAIT_LOW;
               w_next_cnt   = CNT_ONE;
            end else begin
               w_next_cnt   = CNT_ZERO;
            end
         end
         WAIT_LOW: begin
            if (w_s) begin
               w_next_state  = ST_HIGH;
               w_next_cnt    = CNT_ZERO;
               w_next_glitch = 1'b1;
            end else if (r_cnt == CNT_LAST) begin
               w_next_state = ST_LOW;
               w_next_cnt   = CNT_ZERO;
            end else begin
               w_next_cnt   = r_cnt + CNT_ONE;
            end
         end
         default: begin
            w_next_state = RESET_STATE;
            w_next_cnt   = CNT_ZERO;
         end
      endcase
   end

   // State, counter and glitch registers; reset discards any qualification
   // in progress without pulsing glitch.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= RESET_STATE;
         r_cnt    <= CNT_ZERO;
         r_glitch <= 1'b0;
      end else begin
         r_state  <= w_next_state;
         r_cnt    <= w_next_cnt;
         r_glitch <= w_next_glitch;
      end
   end

   // Decode level and busy purely from the state register.
   always_comb begin
      level_o = 1'b0;
      busy_o  = 1'b0;
      case (r_state)
         ST_LOW: begin
            level_o = 1'b0;
            busy_o  = 1'b0;
         end
         WAIT_HIGH: begin
            level_o = 1'b0;
            busy_o  = 1'b1;
         end
         ST_HIGH: begin
            level_o = 1'b1;
            busy_o  = 1'b0;
         end
         WAIT_LOW: begin
            level_o = 1'b1;
            busy_o  = 1'b1;
         end
         default: begin
            level_o = RESET_VAL;
            busy_o  = 1'b0;
         end
      endcase
   end

   assign glitch_o = r_glitch;

endmodule
